// File: rtl/inst_loader_pkg.sv
// Shared widths, state encoding and helpers for the instruction loader.
package inst_loader_pkg;

    localparam int unsigned HDR_W        = 16;
    localparam int unsigned BYTE_W       = 8;
    localparam int unsigned OPCDE_W_DFLT  = 9;
    localparam int unsigned PGMCTR_W_DFLT = 10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEN_LO  = 3'd1,
        LEN_HI  = 3'd2,
        INST_LO = 3'd3,
        INST_HI = 3'd4,
        FIN     = 3'd5
    } ld_state_t;

    // High-byte bits that do not fit into a w-bit instruction (w in 9..16).
    function automatic logic [BYTE_W-1:0] excess_mask(input int unsigned w);
        return 8'hFF << (w - BYTE_W);
    endfunction

endpackage

// File: rtl/inst_loader_asm.sv
// Two-byte instruction assembler with a registered RAM write port.
module inst_loader_asm
    import inst_loader_pkg::*;
#(
    parameter int unsigned OPCDE_W  = OPCDE_W_DFLT,
    parameter int unsigned PGMCTR_W = PGMCTR_W_DFLT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [BYTE_W-1:0]   i_byte,
    input  logic                i_lo_we,
    input  logic                i_hi_we,
    input  logic [PGMCTR_W-1:0] i_addr,
    output logic                o_excess,
    output logic                o_wr_en,
    output logic [PGMCTR_W-1:0] o_wr_addr,
    output logic [OPCDE_W-1:0]  o_wr_data
);

    logic [BYTE_W-1:0]  r_lo;
    logic [OPCDE_W-1:0] w_word;

    // Combine the current high byte with the held low byte; flag dropped bits.
    always_comb begin
        w_word   = OPCDE_W'({i_byte, r_lo});
        o_excess = |(i_byte & excess_mask(OPCDE_W));
    end

    // Hold the low byte, then register the finished word and its address.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lo      <= '0;
            o_wr_en   <= 1'b0;
            o_wr_addr <= '0;
            o_wr_data <= '0;
        end else begin
            o_wr_en <= i_hi_we;
            if (i_lo_we) begin
                r_lo <= i_byte;
            end
            if (i_hi_we) begin
                o_wr_addr <= i_addr;
                o_wr_data <= w_word;
            end
        end
    end

endmodule

// File: rtl/inst_loader.sv
// Program-image loader: parses a byte stream and fills the instruction RAM.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int unsigned OPCDE_W  = OPCDE_W_DFLT,
    parameter int unsigned PGMCTR_W = PGMCTR_W_DFLT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [BYTE_W-1:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                wr_en,
    output logic [PGMCTR_W-1:0] wr_addr,
    output logic [OPCDE_W-1:0]  wr_data,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [HDR_W-1:0]    inst_cnt
);

    ld_state_t          r_state;
    logic               r_in_ready;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic [HDR_W-1:0]   r_inst_cnt;
    // One spare bit so a full-depth image can count to 2**PGMCTR_W without wrapping.
    logic [PGMCTR_W:0]  r_idx;

    logic               w_xfer;
    logic [HDR_W-1:0]   w_count;
    logic               w_oversize;
    logic               w_last;
    logic               w_excess;

    // Handshake and header/index decode.
    always_comb begin
        w_xfer     = in_valid && r_in_ready;
        w_count    = {in_data, r_inst_cnt[BYTE_W-1:0]};
        w_oversize = 32'(w_count) > (32'd1 << PGMCTR_W);
        w_last     = (32'(r_idx) + 32'd1) == 32'(r_inst_cnt);
    end

    // Load sequencer; in_ready, busy and done are registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_inst_cnt <= '0;
            r_idx      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state    <= LEN_LO;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                        r_err      <= 1'b0;
                    end
                end
                LEN_LO: begin
                    if (w_xfer) begin
                        r_inst_cnt[BYTE_W-1:0] <= in_data;
                        r_state                <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (w_xfer) begin
                        r_inst_cnt[HDR_W-1:BYTE_W] <= in_data;
                        r_idx                      <= '0;
                        if (w_count == '0) begin
                            r_state    <= FIN;
                            r_in_ready <= 1'b0;
                        end else if (w_oversize) begin
                            r_err      <= 1'b1;
                            r_state    <= FIN;
                            r_in_ready <= 1'b0;
                        end else begin
                            r_state <= INST_LO;
                        end
                    end
                end
                INST_LO: begin
                    if (w_xfer) begin
                        r_state <= INST_HI;
                    end
                end
                INST_HI: begin
                    if (w_xfer) begin
                        if (w_excess) begin
                            r_err <= 1'b1;
                        end
                        r_idx <= r_idx + 1'b1;
                        if (w_last) begin
                            r_state    <= FIN;
                            r_in_ready <= 1'b0;
                        end else begin
                            r_state <= INST_LO;
                        end
                    end
                end
                FIN: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    inst_loader_asm #(
        .OPCDE_W  (OPCDE_W),
        .PGMCTR_W (PGMCTR_W)
    ) u_asm (
        .clk       (clk),
        .reset     (reset),
        .i_byte    (in_data),
        .i_lo_we   (w_xfer && (r_state == INST_LO)),
        .i_hi_we   (w_xfer && (r_state == INST_HI)),
        .i_addr    (r_idx[PGMCTR_W-1:0]),
        .o_excess  (w_excess),
        .o_wr_en   (wr_en),
        .o_wr_addr (wr_addr),
        .o_wr_data (wr_data)
    );

    always_comb begin
        in_ready = r_in_ready;
        busy     = r_busy;
        done     = r_done;
        err      = r_err;
        inst_cnt = r_inst_cnt;
    end

endmodule

// File: tb/tb_inst_loader.sv
// Scoreboard bench for inst_loader: directed images, expected RAM writes queued.
module tb_inst_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [8:0]  wr_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] inst_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_wr_cyc = -100;
    int wr_total = 0;

    int          exp_addr[$];
    int          exp_data[$];
    logic [7:0]  bq[$];

    inst_loader #(
        .OPCDE_W  (9),
        .PGMCTR_W (10)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .inst_cnt (inst_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Monitor: every write strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            int a;
            int d;
            checks++;
            wr_total++;
            last_wr_cyc = cyc;
            if (exp_addr.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=0x%0h, expected no write", wr_addr, wr_data);
            end else begin
                a = exp_addr.pop_front();
                d = exp_data.pop_front();
                if (int'(wr_addr) != a || int'(wr_data) != d) begin
                    errors++;
                    $display("FAIL write: got addr=%0d data=0x%0h, expected addr=%0d data=0x%0h",
                             wr_addr, wr_data, a, d);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input int a, input int d);
        exp_addr.push_back(a);
        exp_data.push_back(d);
    endtask

    // Caller sits at posedge+1; returns at posedge+1 after the byte transfers.
    task automatic send_byte(input logic [7:0] b, input bit gap);
        bit acc;
        if (gap) begin
            int n;
            n = $urandom_range(0, 2);
            repeat (n) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                start    = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
            start = 1'b0;
        end
        in_valid = 1'b1;
        in_data  = b;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL byte_accept: byte 0x%0h never accepted, expected in_ready within 50 cycles", b);
        end
    endtask

    task automatic send_all(input bit gap);
        while (bq.size() > 0) send_byte(bq.pop_front(), gap);
        in_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("err_clear_on_start", int'(err), 0);
        chk("busy_after_start", int'(busy), 1);
        chk("ready_after_start", int'(in_ready), 1);
    endtask

    // Wait for done; check it follows the last write by one cycle when writes occurred.
    task automatic wait_done(input bit had_writes);
        bit got;
        int dcyc;
        got = 1'b0;
        dcyc = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got = 1'b1;
                dcyc = cyc;
            end
        end
        chk("done_seen", int'(got), 1);
        if (got) begin
            if (had_writes) chk("done_after_last_wr", dcyc - last_wr_cyc, 1);
            chk("busy_at_done", int'(busy), 0);
            @(negedge clk);
            chk("done_one_cycle", int'(done), 0);
        end
        @(posedge clk); #1;
    endtask

    task automatic basic_image();
        bq = '{8'h03, 8'h00, 8'h34, 8'h01, 8'hFF, 8'h00, 8'h00, 8'h01};
        expect_wr(0, 'h134);
        expect_wr(1, 'h0FF);
        expect_wr(2, 'h100);
    endtask

    initial begin
        int wr_before;
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_wr_data", int'(wr_data), 0);
        chk("rst_inst_cnt", int'(inst_cnt), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Basic three-instruction image.
        basic_image();
        do_start();
        send_all(1'b0);
        wait_done(1'b1);
        chk("basic_queue_empty", exp_addr.size(), 0);
        chk("basic_err", int'(err), 0);
        chk("basic_inst_cnt", int'(inst_cnt), 3);

        // Zero-count image.
        wr_before = wr_total;
        bq = '{8'h00, 8'h00};
        do_start();
        send_all(1'b0);
        wait_done(1'b0);
        chk("zero_writes", wr_total - wr_before, 0);
        chk("zero_err", int'(err), 0);
        chk("zero_busy", int'(busy), 0);

        // Oversize count 1025.
        wr_before = wr_total;
        bq = '{8'h01, 8'h04};
        do_start();
        send_all(1'b0);
        wait_done(1'b0);
        chk("over_writes", wr_total - wr_before, 0);
        chk("over_err", int'(err), 1);
        chk("over_inst_cnt", int'(inst_cnt), 'h401);
        chk("over_ready_idle", int'(in_ready), 0);

        // Excess high bits: 0x3AA truncated to 0x1AA, err raised (start clears previous err).
        bq = '{8'h01, 8'h00, 8'hAA, 8'h03};
        expect_wr(0, 'h1AA);
        do_start();
        send_all(1'b0);
        wait_done(1'b1);
        chk("excess_queue_empty", exp_addr.size(), 0);
        chk("excess_err", int'(err), 1);
        chk("excess_inst_cnt", int'(inst_cnt), 1);

        // Backpressure gaps with stray start pulses: same writes as the gap-free run.
        basic_image();
        do_start();
        send_all(1'b1);
        wait_done(1'b1);
        chk("gap_queue_empty", exp_addr.size(), 0);
        chk("gap_err", int'(err), 0);
        chk("gap_inst_cnt", int'(inst_cnt), 3);

        // Full-depth image: 1024 instructions, last write at address 1023.
        bq = '{8'h00, 8'h04};
        for (int i = 0; i < 1024; i++) begin
            int d;
            d = (i * 37 + 5) % 512;
            bq.push_back(8'(d));
            bq.push_back(8'(d >> 8));
            expect_wr(i, d);
        end
        do_start();
        send_all(1'b0);
        wait_done(1'b1);
        chk("full_queue_empty", exp_addr.size(), 0);
        chk("full_err", int'(err), 0);
        chk("full_inst_cnt", int'(inst_cnt), 'h400);

        // Reset after the second instruction of a five-instruction image.
        bq = '{8'h05, 8'h00, 8'h11, 8'h00, 8'h22, 8'h01};
        expect_wr(0, 'h011);
        expect_wr(1, 'h122);
        do_start();
        send_all(1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mid_rst_in_ready", int'(in_ready), 0);
        chk("mid_rst_wr_en", int'(wr_en), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_err", int'(err), 0);
        chk("mid_rst_wr_addr", int'(wr_addr), 0);
        chk("mid_rst_wr_data", int'(wr_data), 0);
        chk("mid_rst_inst_cnt", int'(inst_cnt), 0);
        chk("mid_rst_queue_empty", exp_addr.size(), 0);
        wr_before = wr_total;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_rst_no_writes", wr_total - wr_before, 0);

        // Fresh image after reset starts from address 0.
        bq = '{8'h02, 8'h00, 8'h55, 8'h00, 8'h66, 8'h01};
        expect_wr(0, 'h055);
        expect_wr(1, 'h166);
        do_start();
        send_all(1'b0);
        wait_done(1'b1);
        chk("fresh_queue_empty", exp_addr.size(), 0);
        chk("fresh_inst_cnt", int'(inst_cnt), 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Writer side of the instruction memory: receives a program image as a byte stream over a valid/ready handshake.
- Parses a 16-bit little-endian instruction-count header, then assembles each OPCDE_W-bit instruction from two bytes.
- Writes each instruction sequentially into the instruction RAM write port, starting at address 0.
- Pulses done when the image is complete; the processor uses this pulse as its init/start.

Parameters:
- OPCDE_W, 9, instruction width in bits; legal range 9..16.
- PGMCTR_W, 10, program-counter/address width; memory depth is 2**PGMCTR_W.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a load; sampled only in IDLE.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte this cycle.
- wr_en  output  1  instruction RAM write strobe.
- wr_addr  output  PGMCTR_W  RAM write address.
- wr_data  output  OPCDE_W  RAM write data.
- busy  output  1  load in progress (any state other than IDLE).
- done  output  1  one-cycle pulse when the load finishes.
- err  output  1  sticky error flag; cleared on the next accepted start.
- inst_cnt  output  16  header count latched for the current or last load.

Behaviour:
- Reset (synchronous, active-high, takes priority over everything): state=IDLE; in_ready, wr_en, busy, done, err = 0; wr_addr, wr_data, inst_cnt = 0. Reset mid-load abandons the load with no further writes.
- Byte transfer occurs when in_valid && in_ready. in_ready is a registered function of state: 1 in LEN_LO, LEN_HI, INST_LO, INST_HI; 0 otherwise. in_data is ignored when no transfer occurs.
- States and transitions:
  - IDLE: start -> LEN_LO and clear err. start is ignored in every other state.
  - LEN_LO: on transfer, latch inst_cnt[7:0] -> LEN_HI.
  - LEN_HI: on transfer, latch inst_cnt[15:8], then evaluate the full count:
    - count 0 -> FIN.
    - count > 2**PGMCTR_W -> set err, then FIN with no writes.
    - otherwise -> INST_LO, with the internal index reset to 0.
  - INST_LO: on transfer, hold the low byte -> INST_HI.
  - INST_HI: on transfer:
    - wr_data = {hi[OPCDE_W-9:0], lo}.
    - If any hi bit at position >= OPCDE_W-8 is set, set err; the word is still written, with the excess bits dropped.
    - Increment the index. If index+1 == inst_cnt -> FIN, else -> INST_LO.
  - FIN: done=1 for exactly one cycle -> IDLE.
- Write latency: wr_en is asserted the cycle after the INST_HI transfer, for one cycle, with wr_addr=index and wr_data=assembled word. wr_addr and wr_data hold their values when wr_en=0.
- Throughput: one instruction per two accepted bytes; back-to-back in_valid loses no cycles.
- The done pulse occurs in the cycle after the final wr_en (FIN follows INST_HI).
- Full-depth boundary: count == 2**PGMCTR_W is legal. The last write goes to address 2**PGMCTR_W-1, and the index does not wrap before FIN.
- The stream supplies no images back-to-back without a fresh start. Bytes arriving in IDLE/FIN are not accepted (in_ready=0).

Decomposition:
- Shared package inst_loader_pkg:
  - State enum: IDLE, LEN_LO, LEN_HI, INST_LO, INST_HI, FIN.
  - Header width constant: 16.
  - Byte-width constant: 8.
  - OPCDE_W and PGMCTR_W defaults, mirroring the processor's global width definitions.
- One natural sub-module, inst_loader_asm:
  - Two-byte-to-OPCDE_W assembler, including excess-bit detection.
  - Output register stage driving wr_en, wr_addr and wr_data.
  - The FSM stays in the top level.

Test Plan:
- Basic load, count=3, bytes 03 00 | 34 01 | FF 00 | 00 01 -> writes (0,0x134), (1,0x0FF), (2,0x100); done pulses 1 cycle after the 3rd wr_en; err=0; inst_cnt=3.
- Zero count, bytes 00 00 -> no wr_en; done pulses; busy falls to 0; err=0.
- Oversize count, bytes 01 04 (1025, with PGMCTR_W=10) -> err=1, no writes, done pulses. A later start clears err.
- Excess hi bits, count=1, bytes 01 00 | AA 03 -> writes 0x1AA at address 0; err=1.
- Backpressure/gaps: random in_valid deassertion and start pulses while busy -> writes identical to the gap-free run; extra starts ignored.
- Reset mid-load: assert reset after the 2nd instruction of a count=5 image -> all outputs return to reset values next cycle; no further wr_en; a fresh start loads a new image from address 0.
